// File: rtl/r1024x8_fifo_pkg.sv
// Shared sizing and types for the r1024x8 FIFO controller.
// The controller and its output buffer both import this package.
package r1024x8_fifo_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W:0]   cnt_t;

endpackage

// File: rtl/r1024x8_fifo_obuf.sv
// Two-entry in-order output buffer holding words returned by the RAM.
// A load and a pop in the same cycle shift the buffer and fill it at once.
module r1024x8_fifo_obuf
    import r1024x8_fifo_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              pop,
    output logic [1:0]        ob_cnt,
    output logic [DATA_W-1:0] head
);

    data_t      entry0;
    data_t      entry1;
    logic [1:0] cnt;

    // NOTE: the entries are reset along with the count so that PopData reads 0
    // after reset or flush instead of stale data.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            entry0 <= '0;
            entry1 <= '0;
            cnt    <= 2'd0;
        end else if (clear) begin
            entry0 <= '0;
            entry1 <= '0;
            cnt    <= 2'd0;
        end else begin
            case ({load, pop})
                2'b01: begin
                    entry0 <= entry1;
                    cnt    <= cnt - 2'd1;
                end
                2'b10: begin
                    if (cnt == 2'd0) entry0 <= load_data;
                    else             entry1 <= load_data;
                    cnt <= cnt + 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the incoming word goes behind the survivor.
                    if (cnt == 2'd2) begin
                        entry0 <= entry1;
                        entry1 <= load_data;
                    end else begin
                        entry0 <= load_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ob_cnt = cnt;
    assign head   = entry0;

endmodule

// File: rtl/r1024x8_fifo_ctl.sv
// FIFO controller in front of the r1024x8 dual-port RAM with a first-word-fall-through output.
// Define R1024X8_FIFO_LOWLAT_EN to bypass RAM read data straight to PopData when the buffer is empty.
module r1024x8_fifo_ctl
    import r1024x8_fifo_pkg::*;
#(
    parameter int AFULL_TH  = 1020,
    parameter int AEMPTY_TH = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Flush,
    input  logic              Push,
    input  logic [DATA_W-1:0] PushData,
    input  logic              Pop,
    output logic [DATA_W-1:0] PopData,
    output logic              Valid,
    output logic              Full,
    output logic              Empty,
    output logic              AFull,
    output logic              AEmpty,
    output logic [ADDR_W:0]   Count,
    output logic              Overflow,
    output logic              Underflow,
    output logic [ADDR_W-1:0] Ram_WA,
    output logic [DATA_W-1:0] Ram_WD,
    output logic              Ram_WEN,
    output logic [ADDR_W-1:0] Ram_RA,
    output logic              Ram_RClk_En,
    input  logic [DATA_W-1:0] Ram_RD
);

    addr_t      wr_ptr, rd_ptr;
    cnt_t       ram_cnt, cnt_q, cnt_nxt;
    logic       inflight;
    logic       full_q, empty_q, afull_q, aempty_q, ovf_q, unf_q;
    logic [1:0] ob_cnt;
    data_t      ob_head;
    logic       wr_acc, pop_acc, issue, bypass, ob_load, ob_pop;
    logic [2:0] pending;

`ifdef R1024X8_FIFO_LOWLAT_EN
    assign bypass = (ob_cnt == 2'd0) & inflight;
`else
    assign bypass = 1'b0;
`endif

    assign wr_acc  = Push & ~full_q & ~Flush;
    assign Valid   = (ob_cnt != 2'd0) | bypass;
    assign PopData = bypass ? Ram_RD : ob_head;
    assign pop_acc = Pop & Valid & ~Flush;

    // Words the buffer will have to absorb next cycle; keep it at most 2.
    assign pending = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop_acc};
    assign issue   = (ram_cnt != '0) & (pending < 3'd2) & ~Flush;

    // A bypassed word popped in its return cycle never enters the buffer.
    assign ob_load = inflight & ~(bypass & pop_acc);
    assign ob_pop  = pop_acc & ~bypass;

    assign cnt_nxt = cnt_q + cnt_t'(wr_acc) - cnt_t'(pop_acc);

    // NOTE: every register here uses non-blocking assignment so all state updates
    // see pre-edge values, matching the combinational decode above.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else if (Flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (issue)  rd_ptr <= rd_ptr + 1'b1;
            ram_cnt  <= ram_cnt + cnt_t'(wr_acc) - cnt_t'(issue);
            inflight <= issue;
            cnt_q    <= cnt_nxt;
            full_q   <= (cnt_nxt == cnt_t'(DEPTH));
            empty_q  <= (cnt_nxt == '0);
            afull_q  <= (cnt_nxt >= cnt_t'(AFULL_TH));
            aempty_q <= (cnt_nxt <= cnt_t'(AEMPTY_TH));
            ovf_q    <= ovf_q | (Push & full_q);
            unf_q    <= unf_q | (Pop & ~Valid);
        end
    end

    r1024x8_fifo_obuf u_obuf (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .clear     (Flush),
        .load      (ob_load),
        .load_data (Ram_RD),
        .pop       (ob_pop),
        .ob_cnt    (ob_cnt),
        .head      (ob_head)
    );

    assign Full        = full_q;
    assign Empty       = empty_q;
    assign AFull       = afull_q;
    assign AEmpty      = aempty_q;
    assign Count       = cnt_q;
    assign Overflow    = ovf_q;
    assign Underflow   = unf_q;
    assign Ram_WA      = wr_ptr;
    assign Ram_WD      = PushData;
    assign Ram_WEN     = wr_acc;
    assign Ram_RA      = rd_ptr;
    assign Ram_RClk_En = issue;

endmodule

// File: tb/tb_r1024x8_fifo_ctl.sv
// Self-checking bench for r1024x8_fifo_ctl with a behavioural 1024x8 registered-read RAM.
// A scoreboard queue tracks every accepted word and the cycle from which it must be visible.
module tb_r1024x8_fifo_ctl;
    import r1024x8_fifo_pkg::*;

`ifdef R1024X8_FIFO_LOWLAT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif
    localparam int AFULL_TH  = 1020;
    localparam int AEMPTY_TH = 4;

    logic              Clk, Rst_n, Flush, Push, Pop;
    logic [DATA_W-1:0] PushData, PopData, Ram_WD, Ram_RD;
    logic              Valid, Full, Empty, AFull, AEmpty, Overflow, Underflow;
    logic [ADDR_W:0]   Count;
    logic [ADDR_W-1:0] Ram_WA, Ram_RA;
    logic              Ram_WEN, Ram_RClk_En;

    r1024x8_fifo_ctl #(.AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush), .Push(Push), .PushData(PushData),
        .Pop(Pop), .PopData(PopData), .Valid(Valid), .Full(Full), .Empty(Empty),
        .AFull(AFull), .AEmpty(AEmpty), .Count(Count), .Overflow(Overflow),
        .Underflow(Underflow), .Ram_WA(Ram_WA), .Ram_WD(Ram_WD), .Ram_WEN(Ram_WEN),
        .Ram_RA(Ram_RA), .Ram_RClk_En(Ram_RClk_En), .Ram_RD(Ram_RD)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [DATA_W-1:0] ram_mem [DEPTH];
    always @(posedge Clk) begin
        if (Ram_WEN) ram_mem[Ram_WA] <= Ram_WD;
        if (Ram_RClk_En) Ram_RD <= ram_mem[Ram_RA];
    end

    typedef struct {
        logic [DATA_W-1:0] d;
        int                rdy;
    } ent_t;

    ent_t              sb[$];
    int                checks = 0;
    int                errors = 0;
    int                edges  = 0;
    int                valid_cycles = 0;
    logic              m_ovf, m_unf, m_valid, m_wen;
    logic [ADDR_W-1:0] m_wa;
    logic              d_push, d_pop, d_flush;
    logic [DATA_W-1:0] d_data;

    // Applies inputs for one cycle and checks the pre-edge (combinational) view.
    task automatic drive(input logic push, input logic pop, input logic [DATA_W-1:0] d, input logic flush);
        Push = push; Pop = pop; PushData = d; Flush = flush;
        d_push = push; d_pop = pop; d_data = d; d_flush = flush;
        #1;
        m_valid = 1'b0;
        if (sb.size() != 0) m_valid = (edges >= sb[0].rdy);
        m_wen = push && !flush && (sb.size() < DEPTH);
        if (Valid === 1'b1) valid_cycles++;
        checks++;
        if (Valid !== m_valid) begin
            errors++;
            $display("FAIL valid @edge %0d: got %b expected %b", edges, Valid, m_valid);
        end
        if (m_valid) begin
            checks++;
            if (PopData !== sb[0].d) begin
                errors++;
                $display("FAIL pop_data @edge %0d: got %h expected %h", edges, PopData, sb[0].d);
            end
        end
        checks++;
        if (Ram_WEN !== m_wen) begin
            errors++;
            $display("FAIL ram_wen @edge %0d: got %b expected %b", edges, Ram_WEN, m_wen);
        end
        if (m_wen) begin
            checks++;
            if (Ram_WA !== m_wa || Ram_WD !== d) begin
                errors++;
                $display("FAIL ram_write @edge %0d: got wa=%0d wd=%h expected wa=%0d wd=%h",
                         edges, Ram_WA, Ram_WD, m_wa, d);
            end
        end
    endtask

    // Clocks one edge, updates the scoreboard and checks the registered status.
    task automatic tick();
        ent_t        e;
        logic [17:0] exp_v, got_v;
        @(posedge Clk);
        edges++;
        if (d_flush) begin
            sb.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_wa  = '0;
        end else begin
            if (d_push && sb.size() == DEPTH) m_ovf = 1'b1;
            if (d_pop && !m_valid) m_unf = 1'b1;
            if (d_pop && m_valid) void'(sb.pop_front());
            if (m_wen) begin
                e.d   = d_data;
                e.rdy = edges + LAT;
                sb.push_back(e);
                m_wa++;
            end
        end
        #1;
        exp_v = {(ADDR_W+1)'(sb.size()), sb.size() == DEPTH, sb.size() == 0,
                 sb.size() >= AFULL_TH, sb.size() <= AEMPTY_TH, m_ovf, m_unf, 1'b0};
        got_v = {Count, Full, Empty, AFull, AEmpty, Overflow, Underflow, 1'b0};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL status @edge %0d: got cnt=%0d F/E/AF/AE/OV/UN=%b expected cnt=%0d F/E/AF/AE/OV/UN=%b",
                     edges, got_v[17:7], got_v[6:1], exp_v[17:7], exp_v[6:1]);
        end
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Push = 1'b0; Pop = 1'b0; Flush = 1'b0; PushData = '0;
        Rst_n = 1'b0;
        sb.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_wa = '0; edges = 0;
        repeat (2) @(negedge Clk);
        checks++;
        if ({Valid, Empty, AEmpty, Full, AFull, Overflow, Underflow, Ram_WEN, Ram_RClk_En} !== 9'b011000000
            || Count !== '0 || PopData !== '0) begin
            errors++;
            $display("FAIL reset: got V/E/AE/F/AF/OV/UN/WEN/REN=%b cnt=%0d pd=%h expected 011000000 cnt=0 pd=00",
                     {Valid, Empty, AEmpty, Full, AFull, Overflow, Underflow, Ram_WEN, Ram_RClk_En}, Count, PopData);
        end
        Rst_n = 1'b1;
    endtask

    task automatic test_first_word();
        test_reset();
        drive(1'b1, 1'b0, 8'h11, 1'b0);
        checks++;
        if (Ram_WEN !== 1'b1 || Ram_WA !== '0) begin
            errors++;
            $display("FAIL first_write: got wen=%b wa=%0d expected wen=1 wa=0", Ram_WEN, Ram_WA);
        end
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (Ram_RClk_En !== 1'b1 || Ram_RA !== '0) begin
            errors++;
            $display("FAIL first_issue: got ren=%b ra=%0d expected ren=1 ra=0", Ram_RClk_En, Ram_RA);
        end
        tick();
        for (int i = 1; i < LAT; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b0);
            tick();
        end
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if (Valid !== 1'b1 || PopData !== 8'h11 || Empty !== 1'b0 || Count !== 11'd1) begin
            errors++;
            $display("FAIL first_valid: got v=%b pd=%h e=%b cnt=%0d expected v=1 pd=11 e=0 cnt=1",
                     Valid, PopData, Empty, Count);
        end
        tick();
    endtask

    task automatic test_fill_overflow();
        test_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 8'(i), 1'b0);
            tick();
        end
        checks++;
        if (Full !== 1'b1 || AFull !== 1'b1 || Count !== 11'd1024) begin
            errors++;
            $display("FAIL fill: got full=%b afull=%b cnt=%0d expected full=1 afull=1 cnt=1024", Full, AFull, Count);
        end
        drive(1'b1, 1'b0, 8'hEE, 1'b0);
        tick();
        checks++;
        if (Overflow !== 1'b1 || Count !== 11'd1024) begin
            errors++;
            $display("FAIL overflow: got ovf=%b cnt=%0d expected ovf=1 cnt=1024", Overflow, Count);
        end
    endtask

    // Continues from the full FIFO left by test_fill_overflow.
    task automatic test_back_to_back();
        valid_cycles = 0;
        for (int i = 0; i < 2000; i++) begin
            drive(1'b1, 1'b1, 8'(i * 7 + 3), 1'b0);
            tick();
        end
        checks++;
        if (valid_cycles != 2000 || Count !== 11'd1023) begin
            errors++;
            $display("FAIL stream: got valid_cycles=%0d cnt=%0d expected valid_cycles=2000 cnt=1023",
                     valid_cycles, Count);
        end
    endtask

    task automatic test_underflow();
        test_reset();
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if (Ram_RClk_En !== 1'b0) begin
            errors++;
            $display("FAIL underflow_read: got ren=%b expected ren=0", Ram_RClk_En);
        end
        tick();
        checks++;
        if (Underflow !== 1'b1 || Count !== '0) begin
            errors++;
            $display("FAIL underflow: got unf=%b cnt=%0d expected unf=1 cnt=0", Underflow, Count);
        end
    endtask

    task automatic test_flush();
        test_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
            tick();
        end
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        tick();
        drive(1'b1, 1'b1, 8'hFF, 1'b1);
        tick();
        checks++;
        if (Count !== '0 || Empty !== 1'b1 || Valid !== 1'b0) begin
            errors++;
            $display("FAIL flush: got cnt=%0d e=%b v=%b expected cnt=0 e=1 v=0", Count, Empty, Valid);
        end
        repeat (3) begin
            drive(1'b0, 1'b0, 8'h00, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 8'h5A, 1'b0);
        tick();
        for (int i = 0; i < LAT; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b0);
            tick();
        end
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        tick();
    endtask

`ifdef R1024X8_FIFO_LOWLAT_EN
    task automatic test_lowlat();
        test_reset();
        drive(1'b1, 1'b0, 8'hA5, 1'b0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if (Valid !== 1'b1 || PopData !== 8'hA5) begin
            errors++;
            $display("FAIL lowlat_valid: got v=%b pd=%h expected v=1 pd=a5", Valid, PopData);
        end
        tick();
        checks++;
        if (Empty !== 1'b1 || Valid !== 1'b0) begin
            errors++;
            $display("FAIL lowlat_pop: got e=%b v=%b expected e=1 v=0", Empty, Valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_word();
        test_fill_overflow();
        test_back_to_back();
        test_underflow();
        test_flush();
`ifdef R1024X8_FIFO_LOWLAT_EN
        test_lowlat();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
